command_scheduler: RTL and testbench

COMMAND_SCHEDULER -- requirements
Module: command_scheduler

---
 rtl/command_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_command_scheduler.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_scheduler.sv
// command_scheduler: arbitrates two requesters onto the PSL command bus.
// A 16-entry tag pool and a 9-bit host credit counter gate the grants, and
// PSL responses are routed back to the requester that owns each tag.
//
// Optional feature: define CMD_PARITY_EN to drive odd parity on ah_ctagpar,
// ah_compar and ah_ceapar; without it the three parity outputs are held 0.
//
// Ports
//   ha_pclock, reset_n      clock, asynchronous active-low reset
//   enable                  job running: high opens scheduling, low drains
//   ha_croom                command credits loaded when a job starts
//   req_valid/com/ea/size   per-requester command requests (requester 0 in low bits)
//   req_ready               grant; accepted when req_valid and req_ready are both high
//   ah_c*                   PSL command bus, registered, one cycle after the grant
//   ha_r*                   PSL response bus
//   rsp_valid, rsp_code     one-cycle response strobe to the owning requester
//   idle                    high while the scheduler is idle
//   err_tag                 sticky: a response named a tag that was not outstanding
module command_scheduler (
  input  logic         ha_pclock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [7:0]   ha_croom,
  input  logic [1:0]   req_valid,
  input  logic [25:0]  req_com,
  input  logic [127:0] req_ea,
  input  logic [23:0]  req_size,
  output logic [1:0]   req_ready,
  output logic         ah_cvalid,
  output logic [7:0]   ah_ctag,
  output logic         ah_ctagpar,
  output logic [12:0]  ah_com,
  output logic         ah_compar,
  output logic [2:0]   ah_cabt,
  output logic [63:0]  ah_cea,
  output logic         ah_ceapar,
  output logic [15:0]  ah_cch,
  output logic [11:0]  ah_csize,
  input  logic         ha_rvalid,
  input  logic [7:0]   ha_rtag,
  input  logic [7:0]   ha_response,
  input  logic [8:0]   ha_rcredits,
  output logic [1:0]   rsp_valid,
  output logic [7:0]   rsp_code,
  output logic         idle,
  output logic         err_tag
);

  localparam int unsigned NUM_TAGS   = 16;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned CTAG_W     = 8;
  localparam int unsigned CREDIT_W   = 9;
  localparam int unsigned SUM_W      = 10;
  localparam int unsigned CREDIT_MAX = 511;
  localparam int unsigned COM_W      = 13;
  localparam int unsigned EA_W       = 64;
  localparam int unsigned SIZE_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [COM_W-1:0]  com;
    logic [EA_W-1:0]   ea;
    logic [SIZE_W-1:0] size;
  } cmd_t;

  state_t               state, state_next;
  logic [CREDIT_W-1:0]  credit, credit_next;
  logic [NUM_TAGS-1:0]  tag_busy, tag_busy_next;
  logic [NUM_TAGS-1:0]  tag_owner, tag_owner_next;
  logic                 rr_ptr, rr_ptr_next;

  logic                 free_found;
  logic [TAG_W-1:0]     free_tag;
  logic [1:0]           grant;
  logic                 grant_any;
  logic                 grant_idx;
  cmd_t                 cmd_sel;
  logic                 rsp_hit;
  logic                 rsp_owner;
  logic [TAG_W-1:0]     rsp_tag;
  logic [CREDIT_W-1:0]  rcredit_add;
  logic [SUM_W-1:0]     credit_sum;

  // Lowest free tag from the registered pool, so a tag freed this cycle waits a cycle
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!tag_busy[i] && !free_found) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(i);
      end
    end
  end

  // Round-robin grant; rr_ptr names the requester that currently has priority
  always_comb begin
    grant = 2'b00;
    if (state == ST_RUN && credit != '0 && free_found) begin
      if (!rr_ptr) begin
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
      end else begin
        if (req_valid[1])      grant = 2'b10;
        else if (req_valid[0]) grant = 2'b01;
      end
    end
  end

  assign grant_any = |grant;
  assign grant_idx = grant[1];
  assign req_ready = grant;

  assign cmd_sel = grant_idx ? {req_com[25:13], req_ea[127:64], req_size[23:12]}
                             : {req_com[12:0],  req_ea[63:0],   req_size[11:0]};

  // A response only counts against a tag inside the pool that is currently outstanding
  assign rsp_tag   = ha_rtag[TAG_W-1:0];
  assign rsp_hit   = ha_rvalid && (ha_rtag[CTAG_W-1:TAG_W] == '0) && tag_busy[rsp_tag];
  assign rsp_owner = tag_owner[rsp_tag];

  // Next-state: FSM, credit counter, tag pool and arbitration pointer
  always_comb begin
    state_next     = state;
    tag_busy_next  = tag_busy;
    tag_owner_next = tag_owner;
    rr_ptr_next    = rr_ptr;
    rcredit_add    = ha_rvalid ? ha_rcredits : '0;
    credit_sum     = SUM_W'(credit) + SUM_W'(rcredit_add) - SUM_W'(grant_any);
    credit_next    = (credit_sum > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX)
                                                       : credit_sum[CREDIT_W-1:0];

    if (rsp_hit) begin
      tag_busy_next[rsp_tag] = 1'b0;
    end
    if (grant_any) begin
      tag_busy_next[free_tag]  = 1'b1;
      tag_owner_next[free_tag] = grant_idx;
      rr_ptr_next              = ~grant_idx;
    end

    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next  = ST_RUN;
        credit_next = CREDIT_W'(ha_croom);
      end
      ST_RUN: begin
        if (!enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as soon as the last outstanding tag is being returned
        if (tag_busy_next == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      credit    <= '0;
      tag_busy  <= '0;
      tag_owner <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      state     <= state_next;
      credit    <= credit_next;
      tag_busy  <= tag_busy_next;
      tag_owner <= tag_owner_next;
      rr_ptr    <= rr_ptr_next;
    end
  end

  // Registered command bus and response outputs; payload is zero when no command
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      ah_cvalid <= 1'b0;
      ah_ctag   <= '0;
      ah_com    <= '0;
      ah_cea    <= '0;
      ah_csize  <= '0;
      rsp_valid <= 2'b00;
      rsp_code  <= '0;
      idle      <= 1'b1;
      err_tag   <= 1'b0;
    end else begin
      ah_cvalid <= grant_any;
      ah_ctag   <= grant_any ? CTAG_W'(free_tag) : '0;
      ah_com    <= grant_any ? cmd_sel.com  : '0;
      ah_cea    <= grant_any ? cmd_sel.ea   : '0;
      ah_csize  <= grant_any ? cmd_sel.size : '0;
      rsp_valid <= rsp_hit ? (rsp_owner ? 2'b10 : 2'b01) : 2'b00;
      rsp_code  <= ha_response;
      idle      <= (state_next == ST_IDLE);
      err_tag   <= err_tag | (ha_rvalid & ~rsp_hit);
    end
  end

  assign ah_cabt = '0;
  assign ah_cch  = '0;

`ifdef CMD_PARITY_EN
  // Odd parity registered alongside the command; upper tag bits are zero
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      ah_ctagpar <= 1'b0;
      ah_compar  <= 1'b0;
      ah_ceapar  <= 1'b0;
    end else begin
      ah_ctagpar <= grant_any & ~(^free_tag);
      ah_compar  <= grant_any & ~(^cmd_sel.com);
      ah_ceapar  <= grant_any & ~(^cmd_sel.ea);
    end
  end
`else
  assign ah_ctagpar = 1'b0;
  assign ah_compar  = 1'b0;
  assign ah_ceapar  = 1'b0;
`endif

endmodule

// File: tb/tb_command_scheduler.sv
// Bench for command_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// (tag owner table, integer credit count, job phase).
module tb_command_scheduler;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic         ha_pclock;
  logic         reset_n;
  logic         enable;
  logic [7:0]   ha_croom;
  logic [1:0]   req_valid;
  logic [25:0]  req_com;
  logic [127:0] req_ea;
  logic [23:0]  req_size;
  logic [1:0]   req_ready;
  logic         ah_cvalid;
  logic [7:0]   ah_ctag;
  logic         ah_ctagpar;
  logic [12:0]  ah_com;
  logic         ah_compar;
  logic [2:0]   ah_cabt;
  logic [63:0]  ah_cea;
  logic         ah_ceapar;
  logic [15:0]  ah_cch;
  logic [11:0]  ah_csize;
  logic         ha_rvalid;
  logic [7:0]   ha_rtag;
  logic [7:0]   ha_response;
  logic [8:0]   ha_rcredits;
  logic [1:0]   rsp_valid;
  logic [7:0]   rsp_code;
  logic         idle;
  logic         err_tag;

  command_scheduler dut (
    .ha_pclock   (ha_pclock),
    .reset_n     (reset_n),
    .enable      (enable),
    .ha_croom    (ha_croom),
    .req_valid   (req_valid),
    .req_com     (req_com),
    .req_ea      (req_ea),
    .req_size    (req_size),
    .req_ready   (req_ready),
    .ah_cvalid   (ah_cvalid),
    .ah_ctag     (ah_ctag),
    .ah_ctagpar  (ah_ctagpar),
    .ah_com      (ah_com),
    .ah_compar   (ah_compar),
    .ah_cabt     (ah_cabt),
    .ah_cea      (ah_cea),
    .ah_ceapar   (ah_ceapar),
    .ah_cch      (ah_cch),
    .ah_csize    (ah_csize),
    .ha_rvalid   (ha_rvalid),
    .ha_rtag     (ha_rtag),
    .ha_response (ha_response),
    .ha_rcredits (ha_rcredits),
    .rsp_valid   (rsp_valid),
    .rsp_code    (rsp_code),
    .idle        (idle),
    .err_tag     (err_tag)
  );

  initial begin
    ha_pclock = 1'b0;
    forever #5 ha_pclock = ~ha_pclock;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: job phase, credits as a plain integer, owner per tag (-1 = free)
  int  m_state;
  int  m_credit;
  int  m_rr;
  int  m_owner [16];
  bit  m_err;

  logic        e_cvalid;
  logic [7:0]  e_tag;
  logic [12:0] e_com;
  logic [63:0] e_ea;
  logic [11:0] e_size;
  logic [1:0]  e_rsp_valid;
  logic [7:0]  e_rsp_code;
  logic        e_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_free_tag();
    for (int i = 0; i < 16; i++) if (m_owner[i] < 0) return i;
    return -1;
  endfunction

  function automatic int m_first_busy();
    for (int i = 0; i < 16; i++) if (m_owner[i] >= 0) return i;
    return -1;
  endfunction

  function automatic int m_pick();
    if (m_state != M_RUN || m_credit == 0 || m_free_tag() < 0) return -1;
    if (req_valid[m_rr])     return m_rr;
    if (req_valid[1 - m_rr]) return 1 - m_rr;
    return -1;
  endfunction

  function automatic logic odd_par(input logic [63:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_credit = 0; m_rr = 0; m_err = 1'b0;
    for (int i = 0; i < 16; i++) m_owner[i] = -1;
    e_cvalid = 1'b0; e_tag = '0; e_com = '0; e_ea = '0; e_size = '0;
    e_rsp_valid = 2'b00; e_rsp_code = '0; e_idle = 1'b1;
  endtask

  // One clock of the model, evaluated with the inputs present at the rising edge
  task automatic model_update();
    int g, t, rt;
    g  = m_pick();
    t  = m_free_tag();
    rt = int'(ha_rtag);
    e_rsp_valid = 2'b00;
    e_rsp_code  = ha_response;
    if (ha_rvalid) begin
      if (rt < 16) begin
        if (m_owner[rt] >= 0) begin
          e_rsp_valid = (m_owner[rt] == 1) ? 2'b10 : 2'b01;
          m_owner[rt] = -1;
        end else m_err = 1'b1;
      end else m_err = 1'b1;
    end
    e_cvalid = 1'b0; e_tag = '0; e_com = '0; e_ea = '0; e_size = '0;
    if (g >= 0) begin
      m_owner[t] = g;
      m_rr       = 1 - g;
      e_cvalid   = 1'b1;
      e_tag      = 8'(t);
      e_com      = 13'(req_com >> (13 * g));
      e_ea       = 64'(req_ea >> (64 * g));
      e_size     = 12'(req_size >> (12 * g));
    end
    if (m_state == M_LOAD) m_credit = int'(ha_croom);
    else begin
      m_credit = m_credit - ((g >= 0) ? 1 : 0) + (ha_rvalid ? int'(ha_rcredits) : 0);
      if (m_credit > 511) m_credit = 511;
    end
    case (m_state)
      M_IDLE:  if (enable) m_state = M_LOAD;
      M_LOAD:  m_state = M_RUN;
      M_RUN:   if (!enable) m_state = M_DRAIN;
      default: if (m_first_busy() < 0) m_state = M_IDLE;
    endcase
    e_idle = (m_state == M_IDLE);
  endtask

  task automatic check_outputs();
    logic ep_tag, ep_com, ep_ea;
`ifdef CMD_PARITY_EN
    ep_tag = e_cvalid & odd_par(64'(e_tag));
    ep_com = e_cvalid & odd_par(64'(e_com));
    ep_ea  = e_cvalid & odd_par(e_ea);
`else
    ep_tag = 1'b0; ep_com = 1'b0; ep_ea = 1'b0;
`endif
    chk("ah_cvalid",  64'(ah_cvalid),  64'(e_cvalid));
    chk("ah_ctag",    64'(ah_ctag),    64'(e_tag));
    chk("ah_com",     64'(ah_com),     64'(e_com));
    chk("ah_cea",     ah_cea,          e_ea);
    chk("ah_csize",   64'(ah_csize),   64'(e_size));
    chk("ah_cabt",    64'(ah_cabt),    64'd0);
    chk("ah_cch",     64'(ah_cch),     64'd0);
    chk("ah_ctagpar", 64'(ah_ctagpar), 64'(ep_tag));
    chk("ah_compar",  64'(ah_compar),  64'(ep_com));
    chk("ah_ceapar",  64'(ah_ceapar),  64'(ep_ea));
    chk("rsp_valid",  64'(rsp_valid),  64'(e_rsp_valid));
    chk("rsp_code",   64'(rsp_code),   64'(e_rsp_code));
    chk("idle",       64'(idle),       64'(e_idle));
    chk("err_tag",    64'(err_tag),    64'(m_err));
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step();
    int g;
    #1;
    g = m_pick();
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'(1 << g));
    @(posedge ha_pclock);
    model_update();
    @(negedge ha_pclock);
    check_outputs();
  endtask

  task automatic idle_inputs();
    enable = 1'b0; ha_croom = '0; req_valid = 2'b00;
    req_com = '0; req_ea = '0; req_size = '0;
    ha_rvalid = 1'b0; ha_rtag = '0; ha_response = '0; ha_rcredits = '0;
  endtask

  task automatic set_rsp(input int tag, input int credits, input int code);
    ha_rvalid = 1'b1; ha_rtag = 8'(tag); ha_rcredits = 9'(credits); ha_response = 8'(code);
  endtask

  task automatic rand_payload();
    req_com  = 26'($urandom);
    req_ea   = {$urandom, $urandom, $urandom, $urandom};
    req_size = 24'($urandom);
  endtask

  task automatic check_reset_literal(input string tag);
    chk({tag, "_idle"},      64'(idle),       64'd1);
    chk({tag, "_cvalid"},    64'(ah_cvalid),  64'd0);
    chk({tag, "_ctag"},      64'(ah_ctag),    64'd0);
    chk({tag, "_com"},       64'(ah_com),     64'd0);
    chk({tag, "_cea"},       ah_cea,          64'd0);
    chk({tag, "_csize"},     64'(ah_csize),   64'd0);
    chk({tag, "_parity"},    64'({ah_ctagpar, ah_compar, ah_ceapar}), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid),  64'd0);
    chk({tag, "_rsp_code"},  64'(rsp_code),   64'd0);
    chk({tag, "_err_tag"},   64'(err_tag),    64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready),  64'd0);
  endtask

  // Called on a falling edge: reset pulse through one rising edge
  task automatic pulse_reset(input string tag);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_literal(tag);
    @(negedge ha_pclock);
    reset_n = 1'b1;
  endtask

  // Drop enable and return every outstanding tag until the job is idle
  task automatic drain(input int budget);
    bit done;
    int t;
    enable = 1'b0; req_valid = 2'b00; done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      t = m_first_busy();
      if (t >= 0) set_rsp(t, 1, int'($urandom_range(0, 255)));
      else ha_rvalid = 1'b0;
      step();
      if (m_state == M_IDLE) done = 1'b1;
    end
    ha_rvalid = 1'b0;
    chk("drain_idle", 64'(idle), 64'd1);
  endtask

  logic [7:0]  got_tags [$];
  logic [12:0] got_com  [$];
  logic        first_par;
  logic        exp_par_0a00;
  int          pool [$];

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge ha_pclock);
    pulse_reset("por");

    // Four credits, requester 0 only: tags 0..3, then stall for credit
    enable = 1'b1; ha_croom = 8'd4; req_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      step();
      if (ah_cvalid) got_tags.push_back(ah_ctag);
    end
    chk("a_cmd_count", 64'(got_tags.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < got_tags.size()) chk("a_tag_order", 64'(got_tags[i]), 64'(i));
    #1;
    chk("a_ready_no_credit", 64'(req_ready), 64'd0);
    set_rsp(0, 1, 8'h5A);
    step();
    chk("a_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("a_rsp_code",  64'(rsp_code),  64'h5A);
    ha_rvalid = 1'b0;
    step();
    chk("a_regrant_valid", 64'(ah_cvalid), 64'd1);
    chk("a_regrant_tag",   64'(ah_ctag),   64'd0);
    drain(100);
    pulse_reset("rst2");

    // Both requesters with 16 credits: strict alternation 0,1,0,1
`ifdef CMD_PARITY_EN
    exp_par_0a00 = 1'b1;
`else
    exp_par_0a00 = 1'b0;
`endif
    enable = 1'b1; ha_croom = 8'd16; req_valid = 2'b11;
    req_com = {13'h1555, 13'h0A00};
    req_ea = {$urandom, $urandom, $urandom, $urandom};
    req_size = 24'($urandom);
    got_tags.delete();
    first_par = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ah_cvalid) begin
        if (got_com.size() == 0) first_par = ah_compar;
        got_com.push_back(ah_com);
        got_tags.push_back(ah_ctag);
      end
    end
    chk("b_cmd_count", 64'(got_com.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < got_com.size()) begin
      chk("b_alternate_com", 64'(got_com[i]), (i % 2 == 0) ? 64'h0A00 : 64'h1555);
      chk("b_tag_order", 64'(got_tags[i]), 64'(i));
    end
    chk("b_compar_0a00", 64'(first_par), 64'(exp_par_0a00));

    // Tag 3 belongs to requester 1; its response routes there and the tag is reused
    req_valid = 2'b00;
    set_rsp(3, 0, 8'h00);
    step();
    chk("b_rsp_valid_req1", 64'(rsp_valid), 64'h2);
    chk("b_rsp_code",       64'(rsp_code),  64'h00);
    ha_rvalid = 1'b0; req_valid = 2'b01;
    step();
    chk("b_reuse_valid", 64'(ah_cvalid), 64'd1);
    chk("b_reuse_tag",   64'(ah_ctag),   64'd3);

    // Responses to a free tag and an out-of-range tag
    req_valid = 2'b00;
    set_rsp(9, 2, 8'h33);
    step();
    chk("c_err_set",   64'(err_tag),   64'd1);
    chk("c_no_rsp",    64'(rsp_valid), 64'd0);
    set_rsp(200, 0, 8'h44);
    step();
    chk("c_no_rsp_oor", 64'(rsp_valid), 64'd0);
    ha_rvalid = 1'b0;
    step();
    step();
    chk("c_err_sticky", 64'(err_tag), 64'd1);

    // Three tags outstanding, enable dropped: no grants, idle right after last response
    set_rsp(3, 0, 8'h11);
    step();
    ha_rvalid = 1'b0; enable = 1'b0;
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("d_no_grant_drain", 64'(req_ready), 64'd0);
      step();
    end
    for (int t = 0; t < 3; t++) begin
      set_rsp(t, 1, 8'(t + 1));
      step();
      chk("d_idle_after_rsp", 64'(idle), (t == 2) ? 64'd1 : 64'd0);
    end
    ha_rvalid = 1'b0;

    // Asynchronous reset in the middle of a running job
    enable = 1'b1; ha_croom = 8'd8; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      step();
    end
    chk("e_cvalid_before_reset", 64'(ah_cvalid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_literal("e_async");
    idle_inputs();
    @(negedge ha_pclock);
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < (enable ? 2 : 10)) enable = ~enable;
      req_valid = 2'($urandom);
      rand_payload();
      ha_croom = 8'($urandom_range(0, 40));
      ha_response = 8'($urandom);
      ha_rvalid = 1'b0; ha_rtag = '0; ha_rcredits = '0;
      if ($urandom_range(0, 99) < 30) begin
        pool.delete();
        for (int i = 0; i < 16; i++) if (m_owner[i] >= 0) pool.push_back(i);
        ha_rvalid = 1'b1;
        if (pool.size() > 0 && $urandom_range(0, 99) < 85)
          ha_rtag = 8'(pool[$urandom_range(0, pool.size() - 1)]);
        else if ($urandom_range(0, 9) == 0)
          ha_rtag = 8'($urandom_range(16, 255));
        else
          ha_rtag = 8'($urandom_range(0, 15));
        ha_rcredits = ($urandom_range(0, 19) == 0) ? 9'($urandom_range(200, 511))
                                                   : 9'($urandom_range(0, 2));
      end
      step();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
